// File: rtl/led_sequencer_pkg.sv
// led_seq_pkg: shared encodings for the LED sequencer.
//   - mode encodings (COUNT / SHIFT / BOUNCE / BLINK)
//   - reset value of the speed register
//   - initial LED pattern for each mode, plus a lookup helper
package led_seq_pkg;

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_SHIFT  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [1:0] SPEED_RESET = 2'd2;

    localparam logic [3:0] INIT_COUNT  = 4'b0000;
    localparam logic [3:0] INIT_SHIFT  = 4'b0001;
    localparam logic [3:0] INIT_BOUNCE = 4'b0001;
    localparam logic [3:0] INIT_BLINK  = 4'b0000;

    // Bounce direction bit: up means the lit LED moves towards led[3].
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Pattern loaded into the LED bank when a mode is entered.
    function automatic logic [3:0] init_pattern(input logic [1:0] m);
        logic [3:0] p;
        case (m)
            MODE_COUNT:  p = INIT_COUNT;
            MODE_SHIFT:  p = INIT_SHIFT;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_BLINK:  p = INIT_BLINK;
            default:     p = INIT_COUNT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, level debouncer and rising-edge pulse
// for one raw push button.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   btn    : raw asynchronous button level, active high
//   press  : one-cycle pulse when the accepted level rises
// A clean raw rise yields the pulse 2 + DEBOUNCE_CYCLES + 1 cycles later.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, count stable cycles of a differing level, accept and pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_MAX) begin
                    level_r <= sync2_r;
                    cnt_r   <= {CW{1'b0}};
                    // Only an accepted rise is a press; releases are silent.
                    press_r <= sync2_r;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: owner of the 4-LED bank. Runs a tick-rate counter and steps
// the LEDs through one of four patterns, controlled by three debounced buttons.
//   CLK100MHZ : board clock, rising edge
//   rst_n     : synchronous active-low reset
//   btn_mode  : raw button, press advances the mode
//   btn_speed : raw button, press advances the speed (period = TICK_BASE << speed)
//   btn_pause : raw button, press toggles pause
//   led       : current pattern (registered)
//   mode      : current mode (registered)
//   tick      : one-cycle pulse coincident with each pattern advance (registered)
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_BASE       = 12_500_000
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       btn_pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    logic        mode_press_s;
    logic        speed_press_s;
    logic        pause_press_s;

    logic [3:0]  led_r;
    logic [1:0]  mode_r;
    logic        tick_r;
    logic [1:0]  speed_r;
    logic        paused_r;
    logic        dir_r;
    logic [26:0] cnt_r;

    logic [26:0] last_s;
    logic        terminal_s;
    logic        active_s;
    logic [1:0]  mode_inc_s;
    logic [3:0]  led_next_s;
    logic        dir_next_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(CLK100MHZ), .rst_n(rst_n), .btn(btn_mode), .press(mode_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk(CLK100MHZ), .rst_n(rst_n), .btn(btn_speed), .press(speed_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk(CLK100MHZ), .rst_n(rst_n), .btn(btn_pause), .press(pause_press_s)
    );

    // Terminal count, run enable and next mode.
    always_comb begin
        last_s     = (27'(TICK_BASE) << speed_r) - 27'd1;
        terminal_s = (cnt_r == last_s);
        // A pause press cycle never counts, so entering pause at the terminal
        // count holds period-1 and resuming waits one cycle before running.
        active_s   = !paused_r && !pause_press_s;
        mode_inc_s = mode_r + 2'd1;
    end

    // Next pattern and bounce direction for the current mode.
    always_comb begin
        led_next_s = led_r;
        dir_next_s = dir_r;
        case (mode_r)
            MODE_COUNT:  led_next_s = led_r + 4'd1;
            MODE_SHIFT:  led_next_s = {led_r[2:0], led_r[3]};
            MODE_BOUNCE: begin
                if (dir_r == DIR_UP) begin
                    led_next_s = {led_r[2:0], 1'b0};
                    // Turn as soon as an end is reached so it shows only once.
                    if (led_r == 4'b0100) begin
                        dir_next_s = DIR_DOWN;
                    end else begin
                        dir_next_s = DIR_UP;
                    end
                end else begin
                    led_next_s = {1'b0, led_r[3:1]};
                    if (led_r == 4'b0010) begin
                        dir_next_s = DIR_UP;
                    end else begin
                        dir_next_s = DIR_DOWN;
                    end
                end
            end
            MODE_BLINK:  led_next_s = ~led_r;
            default:     led_next_s = led_r;
        endcase
    end

    // Tick counter, pattern register and mode/speed/pause control.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            led_r    <= 4'b0000;
            mode_r   <= MODE_COUNT;
            tick_r   <= 1'b0;
            speed_r  <= SPEED_RESET;
            paused_r <= 1'b0;
            dir_r    <= DIR_UP;
            cnt_r    <= 27'd0;
        end else begin
            tick_r <= 1'b0;
            if (pause_press_s) begin
                paused_r <= ~paused_r;
            end
            // Mode/speed presses win over a coincident terminal count.
            if (mode_press_s || speed_press_s) begin
                cnt_r <= 27'd0;
                if (mode_press_s) begin
                    mode_r <= mode_inc_s;
                    led_r  <= init_pattern(mode_inc_s);
                    dir_r  <= DIR_UP;
                end
                if (speed_press_s) begin
                    speed_r <= speed_r + 2'd1;
                end
            end else if (active_s) begin
                if (terminal_s) begin
                    cnt_r  <= 27'd0;
                    led_r  <= led_next_s;
                    dir_r  <= dir_next_s;
                    tick_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + 27'd1;
                end
            end
        end
    end

    assign led  = led_r;
    assign mode = mode_r;
    assign tick = tick_r;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized self-checking bench for led_sequencer with
// DEBOUNCE_CYCLES=4 and TICK_BASE=4 (periods 4/8/16/32). A behavioural model
// tracks mode, speed, pause, elapsed cycles and the pattern as a count value,
// a lit-LED position with +/-1 direction, or a blink phase.
module tb_led_sequencer;

    localparam int DB      = 4;
    localparam int TB_BASE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_pause = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;

    led_sequencer #(.DEBOUNCE_CYCLES(DB), .TICK_BASE(TB_BASE)) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .btn_mode(btn_mode),
        .btn_speed(btn_speed), .btn_pause(btn_pause),
        .led(led), .mode(mode), .tick(tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int m_mode, m_speed, m_elapsed, m_count, m_pos, m_dir;
    bit m_paused, m_blink_on, m_tick;
    // Press pulses the model applies at the next edge.
    bit ev_mode = 1'b0, ev_speed = 1'b0, ev_pause = 1'b0;

    function automatic int period_of(input int s);
        return TB_BASE * (1 << s);
    endfunction

    function automatic logic [3:0] model_led();
        case (m_mode)
            0:       return 4'(m_count);
            1, 2:    return 4'(1 << m_pos);
            default: return m_blink_on ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 2; m_elapsed = 0; m_count = 0; m_pos = 0;
        m_dir = 1; m_paused = 1'b0; m_blink_on = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_pattern();
        case (m_mode)
            0: m_count = (m_count + 1) % 16;
            1: m_pos = (m_pos + 1) % 4;
            2: begin
                if (m_pos + m_dir > 3 || m_pos + m_dir < 0) m_dir = -m_dir;
                m_pos = m_pos + m_dir;
            end
            default: m_blink_on = !m_blink_on;
        endcase
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_tick = 1'b0;
            if (ev_mode || ev_speed) begin
                m_elapsed = 0;
                if (ev_mode) begin
                    m_mode = (m_mode + 1) % 4;
                    m_count = 0; m_pos = 0; m_dir = 1; m_blink_on = 1'b0;
                end
                if (ev_speed) m_speed = (m_speed + 1) % 4;
                if (ev_pause) m_paused = !m_paused;
            end else if (ev_pause) begin
                m_paused = !m_paused;
            end else if (!m_paused) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == period_of(m_speed)) begin
                    m_elapsed = 0;
                    m_tick = 1'b1;
                    model_pattern();
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Clean press: hold the raw buttons long enough to be accepted; returns
    // just after the edge where the press takes effect. mask: 0=mode 1=speed 2=pause.
    task automatic press(input logic [2:0] mask);
        btn_mode = mask[0]; btn_speed = mask[1]; btn_pause = mask[2];
        idle(7);
        ev_mode = mask[0]; ev_speed = mask[1]; ev_pause = mask[2];
        step();
        ev_mode = 1'b0; ev_speed = 1'b0; ev_pause = 1'b0;
        btn_mode = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
    endtask

    // Counts edges until tick is seen (bounded at 200).
    task automatic wait_tick(output int n);
        bit got;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            n++;
            if (tick === 1'b1) got = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_mode = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
        ev_mode = 1'b0; ev_speed = 1'b0; ev_pause = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_tests++; if (led !== 4'b0000) begin n_fail++; $display("FAIL reset_led: got %b expected 0000", led); end
        n_tests++; if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        int n;
        for (int k = 0; k < 16; k++) begin
            wait_tick(n);
            n_tests++; if (n !== 16) begin n_fail++; $display("FAIL free_run_interval[%0d]: got %0d expected 16", k, n); end
            n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL free_run_led[%0d]: got %b expected %b", k, led, model_led()); end
            if (k == 0) begin
                n_tests++; if (led !== 4'b0001) begin n_fail++; $display("FAIL free_run_first: got %b expected 0001", led); end
            end
        end
        n_tests++; if (led !== 4'b0000) begin n_fail++; $display("FAIL free_run_wrap: got %b expected 0000", led); end
    endtask

    task automatic test_glitch();
        int n;
        int glen;
        do_reset();
        glen = $urandom_range(1, 3);
        btn_mode = 1'b1;
        idle(glen);
        btn_mode = 1'b0;
        idle(12);
        n_tests++; if (mode !== 2'd0) begin n_fail++; $display("FAIL glitch_ignored: got mode %0d expected 0 (len %0d)", mode, glen); end
        btn_mode = 1'b1;
        idle(7);
        n_tests++; if (mode !== 2'd0) begin n_fail++; $display("FAIL glitch_early: got mode %0d expected 0", mode); end
        ev_mode = 1'b1;
        step();
        ev_mode = 1'b0;
        n_tests++; if (mode !== 2'd1) begin n_fail++; $display("FAIL glitch_mode: got %0d expected 1", mode); end
        n_tests++; if (led !== 4'b0001) begin n_fail++; $display("FAIL glitch_led: got %b expected 0001", led); end
        idle(2);
        btn_mode = 1'b0;
        wait_tick(n);
        n_tests++; if (n + 2 !== 16) begin n_fail++; $display("FAIL glitch_cleared: got %0d expected 16", n + 2); end
        n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL glitch_tick_led: got %b expected %b", led, model_led()); end
    endtask

    task automatic test_modes();
        int n;
        int nt;
        logic [3:0] bounce_seq [7];
        bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        do_reset();
        press(3'b001);
        idle(8);
        press(3'b001);
        n_tests++; if (mode !== 2'd2) begin n_fail++; $display("FAIL bounce_mode: got %0d expected 2", mode); end
        nt = $urandom_range(7, 12);
        for (int k = 0; k < nt; k++) begin
            wait_tick(n);
            n_tests++; if (n !== 16) begin n_fail++; $display("FAIL bounce_interval[%0d]: got %0d expected 16", k, n); end
            n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL bounce_led[%0d]: got %b expected %b", k, led, model_led()); end
            if (k < 7) begin
                n_tests++; if (led !== bounce_seq[k]) begin n_fail++; $display("FAIL bounce_seq[%0d]: got %b expected %b", k, led, bounce_seq[k]); end
            end
        end
        idle(8);
        press(3'b001);
        n_tests++; if (mode !== 2'd3 || led !== 4'b0000) begin n_fail++; $display("FAIL blink_entry: got mode %0d led %b expected 3 0000", mode, led); end
        nt = $urandom_range(4, 8);
        for (int k = 0; k < nt; k++) begin
            wait_tick(n);
            n_tests++; if (led !== model_led() || n !== 16) begin n_fail++; $display("FAIL blink_led[%0d]: got %b after %0d expected %b after 16", k, led, n, model_led()); end
        end
    endtask

    task automatic test_speed();
        int n;
        do_reset();
        press(3'b010);
        wait_tick(n);
        n_tests++; if (n !== (TB_BASE << 3)) begin n_fail++; $display("FAIL speed3_interval: got %0d expected %0d", n, TB_BASE << 3); end
        n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL speed3_led: got %b expected %b", led, model_led()); end
        press(3'b010);
        for (int k = 0; k < 2; k++) begin
            wait_tick(n);
            n_tests++; if (n !== TB_BASE) begin n_fail++; $display("FAIL speed0_interval[%0d]: got %0d expected %0d", k, n, TB_BASE); end
            n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL speed0_led[%0d]: got %b expected %b", k, led, model_led()); end
        end
    endtask

    task automatic test_pause();
        int n;
        int held;
        bit bad;
        logic [3:0] hold_led;
        do_reset();
        idle($urandom_range(5, 30));
        press(3'b100);
        held = m_elapsed;
        hold_led = led;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick !== 1'b0 || led !== hold_led) bad = 1'b1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL pause_hold: outputs moved, led %b expected %b", led, hold_led); end
        n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL pause_led: got %b expected %b", led, model_led()); end
        press(3'b100);
        wait_tick(n);
        n_tests++; if (n !== 16 - held) begin n_fail++; $display("FAIL resume_interval: got %0d expected %0d", n, 16 - held); end
        idle(10);
        press(3'b100);
        idle(5);
        press(3'b001);
        n_tests++; if (mode !== 2'd1 || led !== 4'b0001 || tick !== 1'b0) begin n_fail++; $display("FAIL paused_mode_press: got mode %0d led %b expected 1 0001", mode, led); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick !== 1'b0 || led !== 4'b0001) bad = 1'b1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL paused_after_mode: led %b tick %b expected 0001 0", led, tick); end
        press(3'b100);
        wait_tick(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL resume_cleared: got %0d expected 16", n); end
        n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL resume_led: got %b expected %b", led, model_led()); end
    endtask

    task automatic test_collisions();
        int n;
        int guard;
        bit bad;
        do_reset();
        guard = 0;
        while (m_elapsed != 8 && guard < 40) begin step(); guard++; end
        press(3'b001);
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL collide_mode_tick: got %b expected 0", tick); end
        n_tests++; if (led !== 4'b0001 || mode !== 2'd1) begin n_fail++; $display("FAIL collide_mode_led: got %b mode %0d expected 0001 1", led, mode); end
        wait_tick(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL collide_mode_interval: got %0d expected 16", n); end
        guard = 0;
        while (m_elapsed != 8 && guard < 40) begin step(); guard++; end
        press(3'b100);
        bad = (tick !== 1'b0);
        idle(10);
        if (tick !== 1'b0) bad = 1'b1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL collide_pause_tick: got tick %b expected 0", tick); end
        press(3'b100);
        wait_tick(n);
        n_tests++; if (n !== 1) begin n_fail++; $display("FAIL collide_pause_resume: got %0d expected 1", n); end
        n_tests++; if (led !== model_led()) begin n_fail++; $display("FAIL collide_pause_led: got %b expected %b", led, model_led()); end
        idle(10);
        press(3'b011);
        n_tests++; if (mode !== 2'd2 || led !== 4'b0001) begin n_fail++; $display("FAIL dual_press: got mode %0d led %b expected 2 0001", mode, led); end
        wait_tick(n);
        n_tests++; if (n !== (TB_BASE << 3)) begin n_fail++; $display("FAIL dual_interval: got %0d expected %0d", n, TB_BASE << 3); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit bad;
        do_reset();
        press(3'b001);
        idle(8);
        press(3'b001);
        idle($urandom_range(20, 50));
        btn_speed = 1'b1;
        idle(3);
        rst_n = 1'b0;
        btn_speed = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++; if (led !== 4'b0000 || mode !== 2'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got led %b mode %0d tick %b expected 0000 0 0", led, mode, tick); end
        wait_tick(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL reset_inflight: got %0d expected 16", n); end
        bad = (mode !== 2'd0) || (led !== model_led());
        n_tests++; if (bad) begin n_fail++; $display("FAIL reset_after: got mode %0d led %b expected 0 %b", mode, led, model_led()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_free_run();
        test_glitch();
        test_modes();
        test_speed();
        test_pause();
        test_collisions();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
